// File: rtl/melody_player_pkg.sv
// Shared definitions for the melody player: FSM states, note-entry field layout
// and timing defaults.
package melody_player_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        REST,
        GAP
    } state_t;

    // Note entry layout: [31:16] frequency in Hz, [15:0] duration in ms
    localparam int unsigned FREQ_MSB  = 31;
    localparam int unsigned FREQ_LSB  = 16;
    localparam int unsigned DUR_MSB   = 15;
    localparam int unsigned DUR_LSB   = 0;

    localparam int unsigned DEF_CLK_F = 48;
    localparam int unsigned MS_W      = 16;

    function automatic logic [15:0] entry_freq(input logic [31:0] entry);
        return entry[FREQ_MSB:FREQ_LSB];
    endfunction

    function automatic logic [15:0] entry_dur(input logic [31:0] entry);
        return entry[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/melody_player_if.sv
// Link between the melody player and the downstream tone generator.
interface melody_player_if;
    import melody_player_pkg::*;

    logic [31:0] tone_duration;
    logic [31:0] tone_freq;
    logic        tone_done;

    modport master (output tone_duration, output tone_freq, input tone_done);
    modport slave  (input tone_duration, input tone_freq, output tone_done);

endinterface

// File: rtl/melody_player_ms_timer.sv
// Millisecond timer: CLK_F*1000-cycle prescaler feeding a 16-bit ms counter.
// expired flags the cycle in which the target number of ms completes.
module ms_timer
    import melody_player_pkg::*;
#(
    parameter int unsigned CLK_F = DEF_CLK_F
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic [MS_W-1:0] target,
    output logic            expired
);

    localparam int unsigned TICKS = CLK_F * 1000;
    localparam int unsigned PW    = $clog2(TICKS);

    logic [PW-1:0]   presc;
    logic [MS_W-1:0] ms_cnt;
    logic            tick;

    assign tick = (presc == PW'(TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (tick) begin
            presc  <= '0;
            ms_cnt <= ms_cnt + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A zero target finishes at once; otherwise finish on the tick that completes the last ms.
    always_comb begin
        expired = 1'b0;
        if (target == '0) begin
            expired = 1'b1;
        end else if (tick && (ms_cnt == target - 1'b1)) begin
            expired = 1'b1;
        end
    end

endmodule

// File: rtl/melody_player.sv
// Plays a table of {freq, duration} notes through an external tone generator,
// with rests, inter-note gaps, optional looping and abort.
module melody_player
    import melody_player_pkg::*;
#(
    parameter int unsigned CLK_F = DEF_CLK_F,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_data,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    input  logic [7:0]               gap_ms,
    melody_player_if.master          tone,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] note_idx,
    output logic                     song_done
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]     mem [DEPTH];
    logic [31:0]     rd_data;
    logic [15:0]     rd_freq;
    logic [15:0]     rd_dur;
    logic [MS_W-1:0] rest_dur;
    logic [MS_W-1:0] tmr_target;
    logic            tmr_clear;
    logic            tmr_expired;
    logic            song_end;
    state_t          state;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (state == FETCH) begin
            rd_data <= mem[note_idx];
        end
    end

    assign rd_freq = entry_freq(rd_data);
    assign rd_dur  = entry_dur(rd_data);

    // Timer is held cleared outside REST/GAP and restarted on REST->GAP,
    // so every timed interval begins with a full-length first ms.
    always_comb begin
        tmr_target = {8'h00, gap_ms};
        if (state == REST) begin
            tmr_target = rest_dur;
        end
        tmr_clear = !((state == REST) || (state == GAP)) || ((state == REST) && tmr_expired);
    end

    ms_timer #(
        .CLK_F(CLK_F)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .target (tmr_target),
        .expired(tmr_expired)
    );

    // A zero-duration entry and running past the last entry both end the song.
    always_comb begin
        song_end = 1'b0;
        if ((state == LOAD) && (rd_dur == '0)) begin
            song_end = 1'b1;
        end else if ((state == GAP) && tmr_expired && (note_idx == AW'(DEPTH - 1))) begin
            song_end = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stop) begin
            state              <= IDLE;
            tone.tone_duration <= '0;
            busy               <= 1'b0;
            song_done          <= 1'b0;
            if (rst) begin
                tone.tone_freq <= '0;
                note_idx       <= '0;
                rest_dur       <= '0;
            end
        end else begin
            song_done <= 1'b0;
            if (song_end) begin
                if (loop) begin
                    note_idx <= '0;
                    state    <= FETCH;
                end else begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    song_done <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            note_idx <= '0;
                            busy     <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        if (rd_freq == '0) begin
                            rest_dur <= rd_dur;
                            state    <= REST;
                        end else begin
                            tone.tone_freq     <= {16'h0000, rd_freq};
                            tone.tone_duration <= {16'h0000, rd_dur};
                            state              <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (tone.tone_done) begin
                            tone.tone_duration <= '0;
                            state              <= GAP;
                        end
                    end
                    REST: begin
                        if (tmr_expired) begin
                            state <= GAP;
                        end
                    end
                    GAP: begin
                        if (tmr_expired) begin
                            note_idx <= note_idx + 1'b1;
                            state    <= FETCH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_player.sv
// Self-checking bench for melody_player: a song-level timeline model is compared
// with the DUT outputs every cycle, plus hand-computed literal expectations.
module tb_melody_player;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned IW    = 5;
    localparam int unsigned T     = 1000;   // clocks per ms with CLK_F = 1

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          wr_en   = 1'b0;
    logic [IW-1:0] wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          start   = 1'b0;
    logic          stop    = 1'b0;
    logic          loop    = 1'b0;
    logic [7:0]    gap_ms  = '0;
    logic          busy;
    logic [IW-1:0] note_idx;
    logic          song_done;

    melody_player_if tone_bus ();

    melody_player #(
        .CLK_F(1),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .gap_ms   (gap_ms),
        .tone     (tone_bus),
        .busy     (busy),
        .note_idx (note_idx),
        .song_done(song_done)
    );

    always #5 clk = ~clk;

    // Tone generator stand-in: raises done after 4*duration clocks of a nonzero
    // duration and holds it until the duration returns to 0.
    int unsigned tg_cnt  = 0;
    logic        tg_done = 1'b0;
    assign tone_bus.tone_done = tg_done;
    always @(posedge clk) begin
        if (tone_bus.tone_duration == '0) begin
            tg_cnt  <= 0;
            tg_done <= 1'b0;
        end else begin
            tg_cnt <= tg_cnt + 1;
            if (tg_cnt + 1 >= 4 * tone_bus.tone_duration) tg_done <= 1'b1;
        end
    end

    typedef struct packed {
        logic [31:0]   freq;
        logic [31:0]   dur;
        logic          busy;
        logic [IW-1:0] idx;
        logic          sd;
    } outs_t;

    outs_t       exp_q [$];
    string       lit_name [$];
    longint      lit_act [$];
    longint      lit_exp [$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_freq = '0;

    int          n_total = 0;
    int          n_pass  = 0;
    int          zrun = 0, last_zrun = 0, nzrun = 0, last_nzrun = 0, sd_count = 0;
    logic [IW-1:0] sd_idx = '0;
    logic [31:0] last_nz_freq = '0;

    // Single compare process: per-cycle timeline check, posted literal checks, monitors.
    always @(negedge clk) begin : compare
        outs_t act;
        outs_t e;
        act = {tone_bus.tone_freq, tone_bus.tone_duration, busy, note_idx, song_done};
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (act === e) n_pass++;
            else $display("FAIL cycle_check t=%0t got freq=%0d dur=%0d busy=%0b idx=%0d done=%0b want freq=%0d dur=%0d busy=%0b idx=%0d done=%0b",
                          $time, act.freq, act.dur, act.busy, act.idx, act.sd,
                          e.freq, e.dur, e.busy, e.idx, e.sd);
        end
        while (lit_name.size() != 0) begin
            string  nm;
            longint a;
            longint x;
            nm = lit_name.pop_front();
            a  = lit_act.pop_front();
            x  = lit_exp.pop_front();
            n_total++;
            if (a == x) n_pass++;
            else $display("FAIL %s: got %0d, want %0d", nm, a, x);
        end
        if (tone_bus.tone_duration != '0) begin
            if (zrun != 0) last_zrun = zrun;
            zrun = 0;
            nzrun++;
            last_nz_freq = tone_bus.tone_freq;
        end else begin
            if (nzrun != 0) last_nzrun = nzrun;
            nzrun = 0;
            if (busy) zrun++;
            else zrun = 0;
        end
        if (song_done) begin
            sd_count++;
            sd_idx = note_idx;
        end
    end

    task automatic check(input string name, input longint act, input longint exp_v);
        lit_name.push_back(name);
        lit_act.push_back(act);
        lit_exp.push_back(exp_v);
    endtask

    task automatic push(input logic [31:0] f, input logic [31:0] d, input logic b,
                        input logic [IW-1:0] ix, input logic s, input int unsigned n);
        for (int unsigned j = 0; j < n; j++) exp_q.push_back({f, d, b, ix, s});
    endtask

    task automatic end_song(input bit lp, input logic [IW-1:0] ix);
        if (!lp) begin
            push(last_freq, '0, 1'b0, ix, 1'b1, 1);
            push(last_freq, '0, 1'b0, ix, 1'b0, 3);
        end
    endtask

    // Timeline of one song: each entry costs 2 clocks to read, then a tone
    // (until the generator reports done), a rest or an end; then the gap.
    task automatic sched_song(input int unsigned gap, input bit lp, input int unsigned passes);
        int unsigned gcyc;
        gcyc = (gap == 0) ? 1 : gap * T;
        for (int unsigned p = 0; p < passes; p++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                logic [15:0] f;
                logic [15:0] d;
                f = model_mem[i][31:16];
                d = model_mem[i][15:0];
                push(last_freq, '0, 1'b1, IW'(i), 1'b0, 2);
                if (d == 0) begin
                    end_song(lp, IW'(i));
                    break;
                end
                if (f == 0) begin
                    push(last_freq, '0, 1'b1, IW'(i), 1'b0, d * T);
                end else begin
                    last_freq = {16'h0000, f};
                    push(last_freq, {16'h0000, d}, 1'b1, IW'(i), 1'b0, 4 * d + 1);
                end
                push(last_freq, '0, 1'b1, IW'(i), 1'b0, gcyc);
                if (i == DEPTH - 1) end_song(lp, IW'(i));
            end
        end
    endtask

    task automatic write_entry(input int unsigned a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = IW'(a);
        wr_data = d;
        model_mem[a] = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic start_song();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin : main
        int sd_base;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_freq", tone_bus.tone_freq, 0);
        check("rst_dur", tone_bus.tone_duration, 0);
        check("rst_busy", busy, 0);
        check("rst_idx", note_idx, 0);
        check("rst_song_done", song_done, 0);

        // Single 440 Hz / 3 ms note
        write_entry(0, {16'd440, 16'd3});
        write_entry(1, 32'h0);
        sd_base = sd_count;
        start_song();
        sched_song(0, 1'b0, 1);
        drain();
        check("s1_note_cycles", last_nzrun, 13);
        check("s1_freq", last_nz_freq, 440);
        check("s1_song_done_pulses", sd_count - sd_base, 1);
        check("s1_busy_low", busy, 0);

        // 2 ms rest then 880 Hz: silent from start for 2 + 2000 + 1 + 2 clocks
        write_entry(0, {16'd0, 16'd2});
        write_entry(1, {16'd880, 16'd1});
        write_entry(2, 32'h0);
        start_song();
        sched_song(0, 1'b0, 1);
        drain();
        check("s2_silent_cycles", last_zrun, 2005);
        check("s2_freq", last_nz_freq, 880);

        // 1 ms gap: 1000 gap clocks plus 2 read clocks between tones
        gap_ms = 8'd1;
        write_entry(0, {16'd500, 16'd1});
        write_entry(1, {16'd600, 16'd2});
        write_entry(2, 32'h0);
        start_song();
        sched_song(1, 1'b0, 1);
        drain();
        check("s3_gap_cycles", last_zrun, 1002);
        check("s3_second_note_cycles", last_nzrun, 9);
        gap_ms = 8'd0;

        // Loop twice, then stop during the second PLAY clock of the third pass
        loop = 1'b1;
        write_entry(0, {16'd1000, 16'd1});
        write_entry(1, 32'h0);
        sd_base = sd_count;
        start_song();
        sched_song(0, 1'b1, 2);
        push(last_freq, '0, 1'b1, '0, 1'b0, 2);
        push(32'd1000, 32'd1, 1'b1, '0, 1'b0, 2);
        push(32'd1000, '0, 1'b0, '0, 1'b0, 3);
        repeat (23) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        loop = 1'b0;
        drain();
        check("s4_no_song_done", sd_count - sd_base, 0);
        check("s4_busy_after_stop", busy, 0);
        check("s4_dur_after_stop", tone_bus.tone_duration, 0);

        // All entries nonzero: song ends after entry 31; a mid-song start is ignored
        for (int i = 0; i < DEPTH; i++) write_entry(i, {16'(100 + i), 16'd1});
        sd_base = sd_count;
        start_song();
        sched_song(0, 1'b0, 1);
        repeat (19) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        drain();
        check("s5_song_done_pulses", sd_count - sd_base, 1);
        check("s5_song_done_idx", sd_idx, 31);
        check("s5_last_freq", last_nz_freq, 131);

        // Reset during PLAY, then replay from the untouched memory
        write_entry(0, {16'd700, 16'd2});
        write_entry(1, 32'h0);
        start_song();
        push(last_freq, '0, 1'b1, '0, 1'b0, 2);
        push(32'd700, 32'd2, 1'b1, '0, 1'b0, 2);
        push('0, '0, 1'b0, '0, 1'b0, 3);
        last_freq = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        drain();
        check("s6_freq_after_rst", tone_bus.tone_freq, 0);
        sd_base = sd_count;
        start_song();
        sched_song(0, 1'b0, 1);
        drain();
        check("s6_replay_cycles", last_nzrun, 9);
        check("s6_replay_freq", last_nz_freq, 700);
        check("s6_replay_done", sd_count - sd_base, 1);

        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
